prty_err_mon: RTL and testbench
===============================

// Module: prty_err_mon
// PURPOSE
//  Downstream consumer of the parity checker output. Re-aligns the checker's
//  registered error flag with its data word and forwards an aligned data/valid/error stream.
//  Maintains a saturating error counter, a threshold alarm, a one-shot interrupt,
//  and a first-error capture register for CPU diagnosis. One instance per checked bus.
// PARAMETERS
//  DATA_WTH  531  width of stripped data word (checker DATA_OUT_WTH; 540-bit bus, 64-bit cells)
//  CNT_WTH   16   error counter width
//  ERR_THR   1    err_cnt value at/above which err_alm asserts (1..2^CNT_WTH-1)
// PORTS
//  clks       in   1         system clock, all logic on rising edge
//  rst        in   1         synchronous reset, active-high
//  din_vld    in   1         valid of word presented to checker this cycle
//  din        in   DATA_WTH  checker data_out (same cycle as din_vld)
//  chk_rsult  in   1         checker result; refers to word of previous cycle
//  err_clr    in   1         single-cycle pulse: clear counter, alarm, capture, re-arm
//  dout_vld   out  1         aligned valid (din_vld delayed 1)
//  dout       out  DATA_WTH  aligned data (din delayed 1)
//  dout_err   out  1         parity error of word on dout (= chk_rsult & dout_vld)
//  err_cnt    out  CNT_WTH   saturating count of errored valid words
//  err_alm    out  1         err_cnt >= ERR_THR
//  err_int    out  1         one-cycle pulse on first error after reset/clear
//  cap_vld    out  1         cap_data holds a captured word
//  cap_data   out  DATA_WTH  first errored word since reset/clear
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> ARMED; dout_vld pipeline cleared.
//  Alignment: stage d1 registers din_vld/din each cycle. err_hit = dout_vld & chk_rsult
//   (combinational, same cycle as dout). chk_rsult ignored when dout_vld=0.
//  Latency: din -> dout 1 cycle; err_hit -> err_cnt/cap/err_int visible next cycle (2 from din).
//  Counter: +1 on err_hit; saturates at all-ones, never wraps.
//  err_alm: registered, derived from next err_cnt; deasserts only on clear/reset.
//  FSM (2 states):
//   ARMED: err_hit -> LOCK; load cap_data<=dout, cap_vld<=1, err_int<=1 (one cycle).
//   LOCK : further err_hit only increment counter; cap_data frozen; err_int stays 0.
//          err_clr -> ARMED.
//  err_clr (any state): err_cnt<=0, err_alm<=0, cap_vld<=0, cap_data<=0, FSM->ARMED.
//  err_clr same cycle as err_hit: clear wins, then hit applied: err_cnt<=1,
//   cap_data<=dout, cap_vld<=1, err_int<=1, FSM->LOCK; err_alm<=(ERR_THR<=1).
//  Back-to-back hits: counted every cycle; only first pulses err_int.
//  Reset mid-stream: word in d1 discarded; chk_rsult in first cycle after
//   reset release ignored (dout_vld=0).
//  dout/dout_vld never stalled; no backpressure.
// STRUCTURE
//  Shared include prty_def.vh: FSM encodings (ARMED=1'b0, LOCK=1'b1),
//   prty_wth_cal function, default DATA_WTH/CELL_WTH constants shared with checker.
//  One sub-module: prty_sat_cnt (CNT_WTH, sync clr, inc, saturate, cnt out).
//  Top holds d1 stage, FSM, capture register, alarm compare.
// TESTING
//  1 Clean stream: 100 valid words, chk_rsult=0 -> dout==din delayed 1, err_cnt=0,
//    err_int never, cap_vld=0.
//  2 Single error: word 0x5A..A at cycle 10, chk_rsult=1 cycle 11 -> dout_err=1 cycle 11;
//    cycle 12 err_cnt=1, err_alm=1, err_int one pulse, cap_data=0x5A..A.
//  3 Saturation: CNT_WTH=4, 20 consecutive hits -> err_cnt stops at 15, one err_int,
//    cap_data = first word.
//  4 Clear+hit same cycle: LOCK, err_cnt=7; err_clr with hit on word W -> err_cnt=1,
//    cap_data=W, err_int pulses, FSM LOCK.
//  5 Gap filtering: chk_rsult=1 while dout_vld=0 -> no count, no int.
//  6 Reset mid-stream: rst during burst of hits -> all outputs 0 next cycle; chk_rsult=1
//    first post-reset cycle -> ignored; ERR_THR=3 then needs 3 hits for err_alm.

Source files
------------

// File: rtl/prty_err_mon_pkg.sv
// -----------------------------------------------------------------------------
// prty_err_mon_pkg
// Shared definitions for the parity error monitor slice:
//   mon_state_t    two-state monitor FSM encoding (ARMED / LOCK)
//   prty_wth_cal   stripped data width for a bus carrying one parity bit per cell
//   DEF_*          default widths and threshold used by the monitor
// -----------------------------------------------------------------------------
package prty_err_mon_pkg;

  // ARMED waits for the first error; LOCK holds the captured word until cleared
  typedef enum logic {
    ARMED = 1'b0,
    LOCK  = 1'b1
  } mon_state_t;

  // Data bits left on a bus once every (possibly partial) cell gives up one parity bit
  function automatic int prty_wth_cal(input int bus_wth, input int cell_wth);
    return bus_wth - ((bus_wth + cell_wth - 1) / cell_wth);
  endfunction

  localparam int DEF_BUS_WTH  = 540;
  localparam int DEF_CELL_WTH = 64;
  localparam int DEF_DATA_WTH = prty_wth_cal(DEF_BUS_WTH, DEF_CELL_WTH);
  localparam int DEF_CNT_WTH  = 16;
  localparam int DEF_ERR_THR  = 1;

endpackage

// File: rtl/prty_err_mon_sat_cnt.sv
// -----------------------------------------------------------------------------
// prty_err_mon_sat_cnt
// Saturating up-counter with synchronous clear. A clear and an increment in the
// same cycle leave the counter at 1, so the event that coincides with the clear
// is still counted.
// Ports:
//   clks     in   system clock
//   rst      in   synchronous active-high reset
//   clr      in   clear counter to zero (increment still applied afterwards)
//   inc      in   count one event
//   cnt      out  current count
//   cnt_nxt  out  value cnt takes at the next rising edge
// -----------------------------------------------------------------------------
module prty_err_mon_sat_cnt #(
  parameter int CNT_WTH = 16
) (
  input  logic               clks,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [CNT_WTH-1:0] cnt,
  output logic [CNT_WTH-1:0] cnt_nxt
);

  localparam logic [CNT_WTH-1:0] CNT_ONE = CNT_WTH'(1);

  // Next count: clear first, then apply the increment; hold at all-ones
  // rather than wrapping back to zero
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = inc ? CNT_ONE : '0;
    end else if (inc && (cnt != '1)) begin
      cnt_nxt = cnt + CNT_ONE;
    end
  end

  // Count register
  always_ff @(posedge clks) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/prty_err_mon.sv
// -----------------------------------------------------------------------------
// prty_err_mon
// Consumer of the parity checker. The checker reports its result one cycle
// after the word, so the word is delayed by one stage here to line up with the
// result. Errors are counted (saturating), compared against a threshold, and
// the first errored word after reset/clear is captured for diagnosis along
// with a one-cycle interrupt.
// Ports:
//   clks       in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   din_vld    in   valid of word presented to checker
//   din        in   checker data_out
//   chk_rsult  in   checker result for the previous cycle's word
//   err_clr    in   pulse: clear counter, alarm, capture and re-arm
//   dout_vld   out  din_vld delayed one cycle
//   dout       out  din delayed one cycle
//   dout_err   out  parity error of the word currently on dout
//   err_cnt    out  saturating count of errored valid words
//   err_alm    out  err_cnt at or above ERR_THR
//   err_int    out  one-cycle pulse on first error after reset/clear
//   cap_vld    out  cap_data holds a captured word
//   cap_data   out  first errored word since reset/clear
// -----------------------------------------------------------------------------
module prty_err_mon
  import prty_err_mon_pkg::*;
#(
  parameter int DATA_WTH = DEF_DATA_WTH,
  parameter int CNT_WTH  = DEF_CNT_WTH,
  parameter int ERR_THR  = DEF_ERR_THR
) (
  input  logic                clks,
  input  logic                rst,
  input  logic                din_vld,
  input  logic [DATA_WTH-1:0] din,
  input  logic                chk_rsult,
  input  logic                err_clr,
  output logic                dout_vld,
  output logic [DATA_WTH-1:0] dout,
  output logic                dout_err,
  output logic [CNT_WTH-1:0]  err_cnt,
  output logic                err_alm,
  output logic                err_int,
  output logic                cap_vld,
  output logic [DATA_WTH-1:0] cap_data
);

  localparam logic [CNT_WTH-1:0] THR = CNT_WTH'(ERR_THR);

  mon_state_t         state;
  mon_state_t         state_nxt;
  logic               err_hit;
  logic               cap_load;
  logic [CNT_WTH-1:0] cnt_nxt;

  // Alignment stage: the word sits here during the cycle its checker result arrives
  always_ff @(posedge clks) begin
    if (rst) begin
      dout_vld <= 1'b0;
      dout     <= '0;
    end else begin
      dout_vld <= din_vld;
      dout     <= din;
    end
  end

  // A result only counts while an aligned word is actually present
  assign err_hit  = dout_vld & chk_rsult;
  assign dout_err = err_hit;

  prty_err_mon_sat_cnt #(
    .CNT_WTH(CNT_WTH)
  ) u_sat_cnt (
    .clks    (clks),
    .rst     (rst),
    .clr     (err_clr),
    .inc     (err_hit),
    .cnt     (err_cnt),
    .cnt_nxt (cnt_nxt)
  );

  // Alarm follows the counter's next value so it lines up with err_cnt;
  // the counter only falls on clear/reset, so the alarm does too
  always_ff @(posedge clks) begin
    if (rst) begin
      err_alm <= 1'b0;
    end else begin
      err_alm <= (cnt_nxt >= THR);
    end
  end

  // FSM state register
  always_ff @(posedge clks) begin
    if (rst) begin
      state <= ARMED;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a clear re-arms first, so a hit in the same cycle locks again
  always_comb begin
    state_nxt = state;
    if (err_clr) begin
      state_nxt = err_hit ? LOCK : ARMED;
    end else if ((state == ARMED) && err_hit) begin
      state_nxt = LOCK;
    end
  end

  // FSM output decode: capture on a hit while armed, or while being re-armed
  always_comb begin
    cap_load = err_hit & ((state == ARMED) | err_clr);
  end

  // Capture register and interrupt pulse
  always_ff @(posedge clks) begin
    if (rst) begin
      cap_vld  <= 1'b0;
      cap_data <= '0;
      err_int  <= 1'b0;
    end else begin
      err_int <= cap_load;
      if (cap_load) begin
        cap_vld  <= 1'b1;
        cap_data <= dout;
      end else if (err_clr) begin
        cap_vld  <= 1'b0;
        cap_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prty_err_mon.sv
// -----------------------------------------------------------------------------
// tb_prty_err_mon
// Scoreboard bench for prty_err_mon (CNT_WTH=4, ERR_THR=3). Each issued word
// pushes its expected aligned output and the status expected one cycle later;
// a monitor on the falling edge pops and compares whenever dout_vld is high.
// -----------------------------------------------------------------------------
module tb_prty_err_mon;

  localparam int DW  = 531;
  localparam int CW  = 4;
  localparam int THR = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    logic [CW-1:0] cnt;
    logic          alm;
    logic          intp;
    logic          capv;
    logic [DW-1:0] capd;
  } exp_t;

  logic          clks;
  logic          rst;
  logic          din_vld;
  logic [DW-1:0] din;
  logic          chk_rsult;
  logic          err_clr;
  logic          dout_vld;
  logic [DW-1:0] dout;
  logic          dout_err;
  logic [CW-1:0] err_cnt;
  logic          err_alm;
  logic          err_int;
  logic          cap_vld;
  logic [DW-1:0] cap_data;

  exp_t sb[$];
  int   checks;
  int   errors;
  logic nxt_err;
  logic nxt_clr;

  prty_err_mon #(
    .DATA_WTH(DW),
    .CNT_WTH (CW),
    .ERR_THR (THR)
  ) dut (
    .clks      (clks),
    .rst       (rst),
    .din_vld   (din_vld),
    .din       (din),
    .chk_rsult (chk_rsult),
    .err_clr   (err_clr),
    .dout_vld  (dout_vld),
    .dout      (dout),
    .dout_err  (dout_err),
    .err_cnt   (err_cnt),
    .err_alm   (err_alm),
    .err_int   (err_int),
    .cap_vld   (cap_vld),
    .cap_data  (cap_data)
  );

  // 100 MHz clock
  initial clks = 1'b0;
  always #5 clks = ~clks;

  // Hard stop in case the run never reaches its summary
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] mkw(input logic [7:0] b);
    logic [535:0] t;
    t = {67{b}};
    return t[DW-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: present a new word, and drive the checker result and
  // clear that belong to the word issued on the previous call
  task automatic applyStimulus(input logic vld, input logic [DW-1:0] data, input logic err,
                               input logic clr, input int cnt, input logic alm, input logic intp,
                               input logic capv, input logic [DW-1:0] capd);
    exp_t e;
    @(posedge clks);
    #1;
    chk_rsult = nxt_err;
    err_clr   = nxt_clr;
    din_vld   = vld;
    din       = data;
    nxt_err   = err;
    nxt_clr   = clr;
    if (vld) begin
      e.data = data;
      e.err  = err;
      e.cnt  = CW'(cnt);
      e.alm  = alm;
      e.intp = intp;
      e.capv = capv;
      e.capd = capd;
      sb.push_back(e);
    end
  endtask

  // Synchronous reset for one cycle; ghost drives chk_rsult high in the first
  // cycle after release, when no aligned word exists
  task automatic doReset(input logic ghost);
    @(posedge clks);
    #1;
    rst       = 1'b1;
    din_vld   = 1'b0;
    din       = '0;
    chk_rsult = 1'b0;
    err_clr   = 1'b0;
    nxt_err   = 1'b0;
    nxt_clr   = 1'b0;
    sb.delete();
    @(posedge clks);
    #1;
    rst       = 1'b0;
    chk_rsult = ghost;
    checkOutput("rst_dout_vld", DW'(dout_vld), '0);
    checkOutput("rst_dout",     dout,          '0);
    checkOutput("rst_dout_err", DW'(dout_err), '0);
    checkOutput("rst_err_cnt",  DW'(err_cnt),  '0);
    checkOutput("rst_err_alm",  DW'(err_alm),  '0);
    checkOutput("rst_err_int",  DW'(err_int),  '0);
    checkOutput("rst_cap_vld",  DW'(cap_vld),  '0);
    checkOutput("rst_cap_data", cap_data,      '0);
  endtask

  // Monitor: status of the previously popped word is checked one cycle after it
  // left dout; err_int is checked every cycle so stray pulses are caught
  exp_t pend;
  logic have_pend = 1'b0;
  always @(negedge clks) begin
    if (rst) begin
      have_pend = 1'b0;
    end else begin
      checkOutput("err_int", DW'(err_int), DW'(have_pend ? pend.intp : 1'b0));
      if (have_pend) begin
        checkOutput("err_cnt",  DW'(err_cnt), DW'(pend.cnt));
        checkOutput("err_alm",  DW'(err_alm), DW'(pend.alm));
        checkOutput("cap_vld",  DW'(cap_vld), DW'(pend.capv));
        checkOutput("cap_data", cap_data,     pend.capd);
        have_pend = 1'b0;
      end
      if (dout_vld) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", DW'(1), DW'(0));
        end else begin
          pend = sb.pop_front();
          have_pend = 1'b1;
          checkOutput("dout",     dout,          pend.data);
          checkOutput("dout_err", DW'(dout_err), DW'(pend.err));
        end
      end else begin
        checkOutput("gap_dout_err", DW'(dout_err), '0);
      end
    end
  end

  initial begin
    logic [DW-1:0] w1, w9, s0, q0, z;
    checks    = 0;
    errors    = 0;
    nxt_err   = 1'b0;
    nxt_clr   = 1'b0;
    rst       = 1'b1;
    din_vld   = 1'b0;
    din       = '0;
    chk_rsult = 1'b0;
    err_clr   = 1'b0;
    z         = '0;

    doReset(1'b0);

    // Clean stream: data passes through, nothing counted
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, mkw(8'(i)), 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, z);
    end

    // Gap: result high while no aligned word -> ignored
    applyStimulus(1'b0, mkw(8'hEE), 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, z);
    applyStimulus(1'b1, mkw(8'h33), 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, z);

    // Single error, then accumulate to the threshold of 3
    w1 = mkw(8'h5A);
    applyStimulus(1'b1, w1,          1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1, w1);
    applyStimulus(1'b1, mkw(8'h40),  1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, w1);
    applyStimulus(1'b1, mkw(8'h41),  1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, w1);
    applyStimulus(1'b1, mkw(8'h42),  1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, w1);
    applyStimulus(1'b1, mkw(8'h43),  1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1, w1);

    // Bring the count to 7 while locked, then clear together with a hit
    for (int i = 4; i <= 7; i++) begin
      applyStimulus(1'b1, mkw(8'(8'h50 + i)), 1'b1, 1'b0, i, 1'b1, 1'b0, 1'b1, w1);
    end
    w9 = mkw(8'h99);
    applyStimulus(1'b1, w9,         1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b1, w9);
    applyStimulus(1'b1, mkw(8'h9A), 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, w9);

    // Plain clear without a hit
    applyStimulus(1'b1, mkw(8'hA1), 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, z);
    applyStimulus(1'b1, mkw(8'hA2), 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, z);

    // Saturation: 20 back-to-back hits stop at 15, one interrupt
    s0 = mkw(8'hC0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, mkw(8'(8'hC0 + i)), 1'b1, 1'b0, (i + 1 > 15) ? 15 : i + 1,
                    (i + 1 >= THR), (i == 0), 1'b1, s0);
    end
    applyStimulus(1'b1, mkw(8'hDD), 1'b0, 1'b0, 15, 1'b1, 1'b0, 1'b1, s0);

    // Reset in the middle of a hit burst, with a stray result right after release
    applyStimulus(1'b1, mkw(8'hE0), 1'b1, 1'b0, 15, 1'b1, 1'b0, 1'b1, s0);
    applyStimulus(1'b1, mkw(8'hE1), 1'b1, 1'b0, 15, 1'b1, 1'b0, 1'b1, s0);
    doReset(1'b1);

    // After reset three hits are needed to raise the alarm
    q0 = mkw(8'hF0);
    applyStimulus(1'b1, q0,         1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1, q0);
    applyStimulus(1'b1, mkw(8'hF1), 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, q0);
    applyStimulus(1'b1, mkw(8'hF2), 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, q0);
    applyStimulus(1'b1, mkw(8'hF3), 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1, q0);

    // Drain
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, z, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, z);
    end
    checkOutput("sb_drained", DW'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
